// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: decode/execute pipeline register with valid/ready, flush squash; define ID_EX_SKID_EN for a 2-entry skid buffer
module id_ex_pipe_reg #(
  parameter int CTRL_W     = 10,
  parameter int DATA_W     = 136,
  parameter int CLEAR_DATA = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              accept, xfer;
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid && out_ready;
  assign out_ctrl = out_valid ? ctrl_q : '0;
  assign out_data = data_q;
`ifdef ID_EX_SKID_EN
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t            state_q, state_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_ready_q, in_ready_d;
  assign in_ready   = in_ready_q && !rst;
  assign in_ready_d = state_d != FULL;
  assign out_valid  = state_q != EMPTY;
  assign occupancy  = state_q;
  // next-state: flush squashes both entries, otherwise main/skid FIFO moves
  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    data_d      = data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d     = EMPTY;
      ctrl_d      = '0;
      skid_ctrl_d = '0;
      if (CLEAR_DATA != 0) begin
        data_d      = '0;
        skid_data_d = '0;
      end
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          state_d = ONE;
          ctrl_d  = in_ctrl;
          data_d  = in_data;
        end
        ONE: if (accept && xfer) begin
          ctrl_d = in_ctrl;
          data_d = in_data;
        end else if (xfer) begin
          state_d = EMPTY;
        end else if (accept) begin
          state_d     = FULL;
          skid_ctrl_d = in_ctrl;
          skid_data_d = in_data;
        end
        FULL: if (xfer) begin
          state_d = ONE;
          ctrl_d  = skid_ctrl_q;
          data_d  = skid_data_q;
        end
        default: state_d = EMPTY;
      endcase
    end
  end
  // state registers; in_ready flop resets high so it is 1 right after rst drops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      ctrl_q      <= '0;
      data_q      <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      data_q      <= data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= in_ready_d;
    end
  end
`else
  logic valid_q, valid_d;
  assign in_ready  = out_ready || !valid_q;
  assign out_valid = valid_q;
  assign occupancy = {1'b0, valid_q};
  // next-state: flush beats accept, accept beats a plain transfer
  always_comb begin
    valid_d = flush ? 1'b0 : accept ? 1'b1 : xfer ? 1'b0 : valid_q;
    ctrl_d  = flush ? '0 : accept ? in_ctrl : ctrl_q;
    data_d  = flush ? ((CLEAR_DATA != 0) ? '0 : data_q) : accept ? in_data : data_q;
  end
  // single entry register
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end
`endif
endmodule
